alu_sequencer: RTL and testbench

//  Command-driven controller for the 8-bit combinational ALU: accepts op commands

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencer state type for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_INC  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_ONES = 4'hA;
  localparam logic [3:0] OP_TWOS = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

  // Everything above CLR (D..F) is reserved and reported as an error.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_CLR);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer in front of the 8-bit ALU: runs one op N times into an
// accumulator, performs shifts/load/clear locally, and returns acc and flags.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [7:0]         cmd_data,
  input  logic [COUNT_W-1:0] cmd_count,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero_in,
  input  logic               alu_carry_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_acc,
  output logic               rsp_zero,
  output logic               rsp_carry,
  output logic               rsp_err
);

  seq_state_t         state_q, state_d;
  logic [7:0]         acc_q, acc_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic [3:0]         op_q, op_d;
  logic [7:0]         data_q, data_d;
  logic [COUNT_W-1:0] rem_q, rem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (op_is_legal(cmd_op)) begin
            op_d    = cmd_op;
            data_d  = cmd_data;
            err_d   = 1'b0;
            state_d = EXEC;
            // LOAD/CLR are idempotent, so they always take a single pass.
            if (cmd_op == OP_LOAD || cmd_op == OP_CLR || cmd_count == '0) begin
              rem_d = COUNT_W'(1);
            end else begin
              rem_d = cmd_count;
            end
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_LOAD: begin
            acc_d   = data_q;
            carry_d = 1'b0;
            zero_d  = (data_q == 8'h00);
          end
          OP_CLR: begin
            acc_d   = 8'h00;
            carry_d = 1'b0;
            zero_d  = 1'b1;
          end
          OP_SHR: begin
            acc_d   = {1'b0, acc_q[7:1]};
            carry_d = acc_q[0];
            zero_d  = (acc_q[7:1] == 7'h00);
          end
          OP_SHL: begin
            acc_d   = {acc_q[6:0], 1'b0};
            carry_d = acc_q[7];
            zero_d  = (acc_q[6:0] == 7'h00);
          end
          default: begin
            acc_d   = alu_result;
            zero_d  = alu_zero_in;
            carry_d = alu_carry_in;
          end
        endcase
        rem_d = rem_q - COUNT_W'(1);
        if (rem_q == COUNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs are forced to zero outside EXEC so idle garbage never reaches it.
  assign alu_a      = (state_q == EXEC) ? acc_q  : 8'h00;
  assign alu_b      = (state_q == EXEC) ? data_q : 8'h00;
  assign alu_opcode = (state_q == EXEC) ? op_q   : 4'h0;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_acc   = acc_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: a behavioural ALU sits beside the sequencer, and a
// reference model pushes expected responses into a scoreboard queue.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [7:0]         cmd_data;
  logic [COUNT_W-1:0] cmd_count;
  logic [7:0]         alu_a;
  logic [7:0]         alu_b;
  logic [3:0]         alu_opcode;
  logic [7:0]         alu_result;
  logic               alu_zero_in;
  logic               alu_carry_in;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [7:0]         rsp_acc;
  logic               rsp_zero;
  logic               rsp_carry;
  logic               rsp_err;

  typedef struct packed {
    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic       err;
  } rsp_t;

  rsp_t       expQ[$];
  rsp_t       expRsp;
  logic [7:0] mAcc;
  logic       mZero, mCarry, mErr;
  int         nCmp = 0;
  int         nBad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero_in(alu_zero_in), .alu_carry_in(alu_carry_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // Behavioural ALU: {carry, result}; carry is carry-out for add/inc, borrow for sub/dec.
  function automatic logic [8:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_INC:  return {1'b0, a} + 9'd1;
      OP_DEC:  return {1'b0, a} - 9'd1;
      OP_OR:   return {1'b0, a | b};
      OP_AND:  return {1'b0, a & b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_ONES: return {1'b0, ~a};
      OP_TWOS: return {1'b0, 8'(8'd0 - a)};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] aluOut;
  assign aluOut       = aluModel(alu_opcode, alu_a, alu_b);
  assign alu_result   = aluOut[7:0];
  assign alu_carry_in = aluOut[8];
  assign alu_zero_in  = (aluOut[7:0] == 8'h00);

  task automatic modelCmd(input logic [3:0] op, input logic [7:0] data, input logic [COUNT_W-1:0] count);
    int n;
    logic [8:0] r;
    if (op > OP_CLR) begin
      mErr = 1'b1;
    end else begin
      mErr = 1'b0;
      n = (op == OP_LOAD || op == OP_CLR) ? 1 : ((count == 0) ? 1 : int'(count));
      for (int i = 0; i < n; i++) begin
        case (op)
          OP_LOAD: begin mAcc = data; mCarry = 1'b0; end
          OP_CLR:  begin mAcc = 8'h00; mCarry = 1'b0; end
          OP_SHR:  begin mCarry = mAcc[0]; mAcc = mAcc >> 1; end
          OP_SHL:  begin mCarry = mAcc[7]; mAcc = mAcc << 1; end
          default: begin r = aluModel(op, mAcc, data); mAcc = r[7:0]; mCarry = r[8]; end
        endcase
        mZero = (mAcc == 8'h00);
      end
    end
    expQ.push_back({mAcc, mZero, mCarry, mErr});
  endtask

  // Drive one command, push its expectation, and wait (bounded) for the response.
  // lat counts rising edges from the accepting edge up to the first one after which rsp_valid is seen.
  task automatic issueCmd(input logic [3:0] op, input logic [7:0] data, input logic [COUNT_W-1:0] count,
                          output int lat, output bit ok);
    int waitCnt;
    ok  = 1'b1;
    lat = 0;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    cmd_valid = 1'b1;
    modelCmd(op, data, count);
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      ok = 1'b0;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) ok = 1'b0;
  endtask

  task automatic releaseRsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nCmp++;
    if ({cmd_ready, rsp_valid, alu_a, alu_b, alu_opcode} !== 21'd0) begin
      nBad++;
      $display("[TB] FAIL reset_hold: ready=%b valid=%b a=%h b=%h op=%h, want all 0",
               cmd_ready, rsp_valid, alu_a, alu_b, alu_opcode);
    end
    reset = 1'b0;
    mAcc = 8'h00; mZero = 1'b0; mCarry = 1'b0; mErr = 1'b0;
    @(negedge clk);
    nCmp++;
    if ({rsp_acc, rsp_zero, rsp_carry, rsp_err, cmd_ready} !== {8'h00, 4'b0001}) begin
      nBad++;
      $display("[TB] FAIL reset_state: acc=%h z=%b c=%b e=%b ready=%b, want 00/0/0/0 ready=1",
               rsp_acc, rsp_zero, rsp_carry, rsp_err, cmd_ready);
    end
  endtask

  task automatic test_load_latency();
    int lat;
    bit ok;
    issueCmd(OP_LOAD, 8'h7F, 4'd0, lat, ok);
    expRsp = expQ.pop_front();
    nCmp++;
    if (!ok || lat != 2) begin
      nBad++;
      $display("[TB] FAIL load_latency: got %0d (ok=%b), want 2", lat, ok);
    end
    nCmp++;
    if ({rsp_acc, rsp_zero, rsp_carry, rsp_err} !== {8'h7F, 3'b000} || expRsp !== {8'h7F, 3'b000}) begin
      nBad++;
      $display("[TB] FAIL load_7f: got %h/%b/%b/%b, want 7f/0/0/0",
               rsp_acc, rsp_zero, rsp_carry, rsp_err);
    end
    releaseRsp();
  endtask

  task automatic test_inc_wrap();
    int lat;
    bit ok;
    logic [3:0]  ops[3]  = '{OP_LOAD, OP_INC, OP_DEC};
    logic [7:0]  dats[3] = '{8'hFE, 8'h00, 8'h00};
    logic [3:0]  cnts[3] = '{4'd1, 4'd3, 4'd1};
    logic [10:0] want[3] = '{{8'hFE, 3'b000}, {8'h01, 3'b000}, {8'h00, 3'b100}};
    for (int i = 0; i < 3; i++) begin
      issueCmd(ops[i], dats[i], cnts[i], lat, ok);
      expRsp = expQ.pop_front();
      nCmp++;
      if (!ok || {rsp_acc, rsp_zero, rsp_carry, rsp_err} !== want[i] || expRsp !== want[i]) begin
        nBad++;
        $display("[TB] FAIL inc_wrap[%0d]: got %h/%b/%b/%b ok=%b, want %h (acc,z,c,e)",
                 i, rsp_acc, rsp_zero, rsp_carry, rsp_err, ok, want[i]);
      end
      releaseRsp();
    end
  endtask

  task automatic test_shifts();
    int lat;
    bit ok;
    logic [3:0]  ops[3]  = '{OP_LOAD, OP_SHL, OP_SHR};
    logic [3:0]  cnts[3] = '{4'd1, 4'd1, 4'd2};
    logic [10:0] want[3] = '{{8'h81, 3'b000}, {8'h02, 3'b010}, {8'h00, 3'b110}};
    for (int i = 0; i < 3; i++) begin
      issueCmd(ops[i], 8'h81, cnts[i], lat, ok);
      expRsp = expQ.pop_front();
      nCmp++;
      if (!ok || {rsp_acc, rsp_zero, rsp_carry, rsp_err} !== want[i] || expRsp !== want[i]) begin
        nBad++;
        $display("[TB] FAIL shifts[%0d]: got %h/%b/%b/%b ok=%b, want %h (acc,z,c,e)",
                 i, rsp_acc, rsp_zero, rsp_carry, rsp_err, ok, want[i]);
      end
      releaseRsp();
    end
  endtask

  task automatic test_illegal();
    int lat;
    bit ok;
    issueCmd(4'hE, 8'h55, 4'd3, lat, ok);
    expRsp = expQ.pop_front();
    nCmp++;
    if (!ok || lat != 1) begin
      nBad++;
      $display("[TB] FAIL illegal_latency: got %0d (ok=%b), want 1", lat, ok);
    end
    nCmp++;
    if ({rsp_acc, rsp_zero, rsp_carry, rsp_err} !== expRsp || rsp_err !== 1'b1) begin
      nBad++;
      $display("[TB] FAIL illegal_rsp: got %h/%b/%b/%b, want %h/%b/%b/1",
               rsp_acc, rsp_zero, rsp_carry, rsp_err, expRsp.acc, expRsp.zero, expRsp.carry);
    end
    releaseRsp();
    issueCmd(OP_LOAD, 8'h33, 4'd0, lat, ok);
    expRsp = expQ.pop_front();
    nCmp++;
    if (!ok || {rsp_acc, rsp_zero, rsp_carry, rsp_err} !== {8'h33, 3'b000} || expRsp !== {8'h33, 3'b000}) begin
      nBad++;
      $display("[TB] FAIL err_clear: got %h/%b/%b/%b ok=%b, want 33/0/0/0",
               rsp_acc, rsp_zero, rsp_carry, rsp_err, ok);
    end
    releaseRsp();
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    logic [10:0] snap;
    issueCmd(OP_ADD, 8'h10, 4'd2, lat, ok);
    expRsp = expQ.pop_front();
    snap = {rsp_acc, rsp_zero, rsp_carry, rsp_err};
    nCmp++;
    if (!ok || snap !== expRsp || snap !== {8'h53, 3'b000}) begin
      nBad++;
      $display("[TB] FAIL bp_rsp: got %h ok=%b, want %h (acc,z,c,e)", snap, ok, expRsp);
    end
    cmd_valid = 1'b1;
    cmd_op    = OP_CLR;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nCmp++;
      if ({rsp_acc, rsp_zero, rsp_carry, rsp_err} !== snap || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
        nBad++;
        $display("[TB] FAIL bp_hold[%0d]: got %h valid=%b ready=%b, want %h valid=1 ready=0",
                 i, {rsp_acc, rsp_zero, rsp_carry, rsp_err}, rsp_valid, cmd_ready, snap);
      end
    end
    cmd_valid = 1'b0;
    releaseRsp();
    @(negedge clk);
    nCmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_acc !== snap[10:3]) begin
      nBad++;
      $display("[TB] FAIL bp_release: valid=%b ready=%b acc=%h, want valid=0 ready=1 acc=%h",
               rsp_valid, cmd_ready, rsp_acc, snap[10:3]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    logic [3:0] pool[12] = '{OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_OR, OP_AND,
                             OP_XOR, OP_SHR, OP_SHL, OP_ONES, OP_TWOS, OP_LOAD};
    logic [3:0] op;
    logic [3:0] cnt;
    for (int i = 0; i < 14; i++) begin
      op  = pool[$urandom_range(0, 11)];
      cnt = 4'($urandom_range(0, 4));
      issueCmd(op, 8'($urandom_range(0, 255)), cnt, lat, ok);
      expRsp = expQ.pop_front();
      nCmp++;
      if (!ok || {rsp_acc, rsp_zero, rsp_carry, rsp_err} !== expRsp) begin
        nBad++;
        $display("[TB] FAIL b2b[%0d] op=%h cnt=%0d: got %h/%b/%b/%b ok=%b, want %h/%b/%b/%b",
                 i, op, cnt, rsp_acc, rsp_zero, rsp_carry, rsp_err, ok,
                 expRsp.acc, expRsp.zero, expRsp.carry, expRsp.err);
      end
      nCmp++;
      if (!ok || lat != ((op == OP_LOAD || cnt == 0) ? 2 : int'(cnt) + 1)) begin
        nBad++;
        $display("[TB] FAIL b2b_latency[%0d]: got %0d, want %0d", i, lat,
                 (op == OP_LOAD || cnt == 0) ? 2 : int'(cnt) + 1);
      end
      releaseRsp();
    end
  endtask

  task automatic test_reset_abort();
    int  waitCnt;
    bit  sawValid;
    @(negedge clk);
    cmd_op = OP_ADD; cmd_data = 8'h05; cmd_count = 4'd15; cmd_valid = 1'b1;
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    nCmp++;
    if (alu_opcode !== OP_ADD || rsp_valid !== 1'b0) begin
      nBad++;
      $display("[TB] FAIL abort_exec: alu_opcode=%h valid=%b, want 1 valid=0", alu_opcode, rsp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    nCmp++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_opcode !== 4'h0) begin
      nBad++;
      $display("[TB] FAIL abort_in_reset: ready=%b valid=%b op=%h, want 0/0/0", cmd_ready, rsp_valid, alu_opcode);
    end
    @(negedge clk);
    reset = 1'b0;
    mAcc = 8'h00; mZero = 1'b0; mCarry = 1'b0; mErr = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) sawValid = 1'b1;
    end
    nCmp++;
    if (sawValid || {rsp_acc, rsp_zero, rsp_carry, rsp_err} !== {mAcc, mZero, mCarry, mErr} || cmd_ready !== 1'b1) begin
      nBad++;
      $display("[TB] FAIL abort_after: sawValid=%b acc=%h z=%b c=%b ready=%b, want 0/00/0/0/1",
               sawValid, rsp_acc, rsp_zero, rsp_carry, cmd_ready);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0; rsp_ready = 1'b0;
    test_reset();
    test_load_latency();
    test_inc_wrap();
    test_shifts();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
